// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 issue front-end.
// Pure declarations and small classification helpers; no state.
package fma16_pkg;

  typedef enum logic [2:0] {
    OP_FADD    = 3'd0,
    OP_FSUB    = 3'd1,
    OP_FMUL    = 3'd2,
    OP_FMADD   = 3'd3,
    OP_FMSUB   = 3'd4,
    OP_FNMADD  = 3'd5,
    OP_FNMSUB  = 3'd6,
    OP_ILLEGAL = 3'd7
  } fma_op_t;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  localparam int NV = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RDN = 2'd2;
  localparam logic [1:0] RM_RUP = 2'd3;

  typedef struct packed {
    fma_op_t     op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [1:0]  roundmode;
  } fma_req_t;

  function automatic logic fp16_is_nan(input logic [15:0] v);
    return (&v[14:10]) & (|v[9:0]);
  endfunction

  function automatic logic fp16_is_snan(input logic [15:0] v);
    return fp16_is_nan(v) & ~v[9];
  endfunction

  function automatic logic fp16_is_inf(input logic [15:0] v);
    return (&v[14:10]) & ~(|v[9:0]);
  endfunction

  function automatic logic fp16_is_zero(input logic [15:0] v);
    return ~(|v[14:0]);
  endfunction

endpackage

// File: rtl/fma16.sv
// Combinational binary16 fused multiply-add: (-1)^negr * (x*y + (-1)^negz * (add ? z : 0)).
// Exact sum in an 82-bit fixed-point window, then one rounding step.
module fma16 import fma16_pkg::*; (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        add,
  input  logic        negr,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  localparam int W = 82;

  logic [15:0]  zv;
  logic         sp, sz, rsign, g, st, inc, nx, uf, inv, anynan, huge;
  logic [4:0]   ex, ey, ez;
  logic [10:0]  mx, my, mz;
  logic [21:0]  mp;
  logic [5:0]   shp, shz;
  logic [W-1:0] pm, zm, mag;
  logic [6:0]   p, sh;
  logic [11:0]  kept, rnd;
  logic [7:0]   ef;
  logic [9:0]   mant;

  // Without an addend, a zero of the product's own sign keeps exact-zero signs right.
  assign zv = add ? z : {x[15] ^ y[15] ^ negz, 15'd0};
  assign sp = x[15] ^ y[15] ^ negr;
  assign sz = zv[15] ^ negz ^ negr;

  assign ex = (x[14:10] == 5'd0)  ? 5'd1 : x[14:10];
  assign ey = (y[14:10] == 5'd0)  ? 5'd1 : y[14:10];
  assign ez = (zv[14:10] == 5'd0) ? 5'd1 : zv[14:10];
  assign mx = {|x[14:10], x[9:0]};
  assign my = {|y[14:10], y[9:0]};
  assign mz = {|zv[14:10], zv[9:0]};

  // Window LSB is 2^-48: the smallest product ulp.
  assign mp  = 22'(mx) * 22'(my);
  assign shp = 6'(ex) + 6'(ey) - 6'd2;
  assign shz = 6'(ez) + 6'd23;
  assign pm  = W'(mp) << shp;
  assign zm  = W'(mz) << shz;

  assign inv = fp16_is_snan(x) | fp16_is_snan(y) | fp16_is_snan(zv)
             | (fp16_is_inf(x) & fp16_is_zero(y)) | (fp16_is_zero(x) & fp16_is_inf(y))
             | ((fp16_is_inf(x) | fp16_is_inf(y)) & fp16_is_inf(zv) & (sp != sz));
  assign anynan = fp16_is_nan(x) | fp16_is_nan(y) | fp16_is_nan(zv);
  assign huge = (roundmode == RM_RTZ) | ((roundmode == RM_RDN) & ~rsign)
              | ((roundmode == RM_RUP) & rsign);

  always_comb begin
    if (sp == sz) begin
      mag = pm + zm;  rsign = sp;
    end else if (pm >= zm) begin
      mag = pm - zm;  rsign = sp;
    end else begin
      mag = zm - pm;  rsign = sz;
    end
    if ((mag == '0) && (sp != sz)) rsign = (roundmode == RM_RDN);

    p = '0;
    for (int i = 0; i < W; i++) if (mag[i]) p = 7'(i);
    // Bit 24 of the window is the subnormal ulp (2^-24).
    sh   = (p > 7'd34) ? p - 7'd10 : 7'd24;
    kept = 12'(mag >> sh);
    g    = mag[sh - 7'd1];
    st   = |(mag & ~({W{1'b1}} << (sh - 7'd1)));
    case (roundmode)
      RM_RNE:  inc = g & (st | kept[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = rsign & (g | st);
      default: inc = ~rsign & (g | st);
    endcase
    rnd = kept + 12'(inc);
    if (rnd[11]) begin
      ef = 8'(sh) - 8'd22;  mant = rnd[10:1];
    end else if (rnd[10]) begin
      ef = 8'(sh) - 8'd23;  mant = rnd[9:0];
    end else begin
      ef = 8'd0;            mant = rnd[9:0];
    end
    nx = g | st;
    uf = nx & ~kept[10];

    if (inv | anynan) begin
      result = FP16_QNAN;               flags = {inv, 3'b000};
    end else if (fp16_is_inf(x) | fp16_is_inf(y)) begin
      result = {sp, 15'h7C00};          flags = 4'b0000;
    end else if (fp16_is_inf(zv)) begin
      result = {sz, 15'h7C00};          flags = 4'b0000;
    end else if (ef >= 8'd31) begin
      result = {rsign, huge ? 15'h7BFF : 15'h7C00};
      flags  = 4'b0101;
    end else begin
      result = {rsign, ef[4:0], mant};  flags = {2'b00, uf, nx};
    end
  end
endmodule

// File: rtl/fma16_opfifo.sv
// Request FIFO: DEPTH entries, head visible combinationally from the storage register.
// Push is accepted only while not full; a pop never frees a slot for a same-cycle push.
module fma16_opfifo import fma16_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  fma_req_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output fma_req_t head
);
  localparam int AW = $clog2(DEPTH);

  fma_req_t        mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];
endmodule

// File: rtl/fma16_issue.sv
// Issue front-end: request FIFO -> decode -> fma16 -> registered result, 2-cycle latency.
// in_ready drops when the FIFO is full; the output register holds while out_ready is low.
module fma16_issue import fma16_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_z,
  input  logic [1:0]  in_roundmode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags,
  output logic [3:0]  fflags,
  input  logic        fflags_clr
);
  fma_req_t    req, head;
  logic        full, empty, head_valid, push, load;
  logic        mul, add, negr, negz, illegal;
  logic [15:0] yop, fma_result, cap_result;
  logic [3:0]  fma_flags, cap_flags;

  assign req        = '{op: fma_op_t'(in_op), x: in_x, y: in_y, z: in_z, roundmode: in_roundmode};
  assign in_ready   = ~full;
  assign push       = in_valid & in_ready;
  assign head_valid = ~empty;
  assign load       = head_valid & (~out_valid | out_ready);

  fma16_opfifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (req),
    .pop       (load),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_comb begin
    mul = 1'b0; add = 1'b0; negr = 1'b0; negz = 1'b0; illegal = 1'b0;
    case (head.op)
      OP_FADD:   add = 1'b1;
      OP_FSUB:   begin add = 1'b1; negz = 1'b1; end
      OP_FMUL:   mul = 1'b1;
      OP_FMADD:  begin mul = 1'b1; add = 1'b1; end
      OP_FMSUB:  begin mul = 1'b1; add = 1'b1; negz = 1'b1; end
      OP_FNMADD: begin mul = 1'b1; add = 1'b1; negr = 1'b1; end
      OP_FNMSUB: begin mul = 1'b1; add = 1'b1; negr = 1'b1; negz = 1'b1; end
      default:   illegal = 1'b1;
    endcase
  end

  assign yop = mul ? head.y : FP16_ONE;

  fma16 u_fma16 (
    .x         (head.x),
    .y         (yop),
    .z         (head.z),
    .add       (add),
    .negr      (negr),
    .negz      (negz),
    .roundmode (head.roundmode),
    .result    (fma_result),
    .flags     (fma_flags)
  );

  assign cap_result = illegal ? FP16_QNAN : fma_result;
  assign cap_flags  = illegal ? 4'(1 << NV) : fma_flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      fflags     <= '0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        out_result <= cap_result;
        out_flags  <= cap_flags;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
      // A clear coinciding with a load keeps the newly captured flags.
      fflags <= (fflags_clr ? 4'd0 : fflags) | (load ? cap_flags : 4'd0);
    end
  end
endmodule

// File: tb/tb_fma16_issue.sv
// Directed bench for fma16_issue: latency, throughput, stalls, flags, illegal op, reset.
module tb_fma16_issue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready, out_valid, out_ready, fflags_clr;
  logic [2:0]  in_op;
  logic [15:0] in_x, in_y, in_z, out_result;
  logic [1:0]  in_roundmode;
  logic [3:0]  out_flags, fflags;
  int          asserts = 0;
  int          errors = 0;

  fma16_issue #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_roundmode(in_roundmode),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .fflags(fflags), .fflags_clr(fflags_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] x, y, z);
    in_valid = v; in_op = op; in_x = x; in_y = y; in_z = z; in_roundmode = 2'd0;
  endtask

  task automatic test_reset;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    out_ready = 1'b1; fflags_clr = 1'b0; reset = 1'b1;
    #3;
    asserts++; if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready got %b want 1", in_ready); errors++; end
    asserts++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid got %b want 0", out_valid); errors++; end
    asserts++; if (out_result !== 16'h0000) begin $display("FAIL rst_result got %h want 0000", out_result); errors++; end
    asserts++; if (out_flags !== 4'b0000) begin $display("FAIL rst_flags got %b want 0000", out_flags); errors++; end
    asserts++; if (fflags !== 4'b0000) begin $display("FAIL rst_fflags got %b want 0000", fflags); errors++; end
    tick; tick;
    reset = 1'b0;
    #2;
    asserts++; if (in_ready !== 1'b1) begin $display("FAIL post_rst_in_ready got %b want 1", in_ready); errors++; end
    tick;
  endtask

  task automatic test_latency;
    drive(1'b1, 3'd2, 16'h4000, 16'h4200, 16'h0000);
    asserts++; if (in_ready !== 1'b1) begin $display("FAIL lat_in_ready got %b want 1", in_ready); errors++; end
    tick;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    asserts++; if (out_valid !== 1'b0) begin $display("FAIL lat_early_valid got %b want 0", out_valid); errors++; end
    tick;
    asserts++; if (out_valid !== 1'b1) begin $display("FAIL lat_valid got %b want 1", out_valid); errors++; end
    asserts++; if (out_result !== 16'h4600) begin $display("FAIL lat_result got %h want 4600", out_result); errors++; end
    asserts++; if (out_flags !== 4'b0000) begin $display("FAIL lat_flags got %b want 0000", out_flags); errors++; end
    tick;
    asserts++; if (out_valid !== 1'b0) begin $display("FAIL lat_drain got %b want 0", out_valid); errors++; end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 3'd0, 16'h3C00, 16'h1234, 16'h3C00);
    tick;
    drive(1'b1, 3'd1, 16'h3C00, 16'h1234, 16'h3C00);
    tick;
    asserts++; if (out_valid !== 1'b1 || out_result !== 16'h4000) begin $display("FAIL b2b_fadd got v=%b %h want v=1 4000", out_valid, out_result); errors++; end
    drive(1'b1, 3'd3, 16'h4000, 16'h4200, 16'h3C00);
    tick;
    asserts++; if (out_valid !== 1'b1 || out_result !== 16'h0000) begin $display("FAIL b2b_fsub got v=%b %h want v=1 0000", out_valid, out_result); errors++; end
    asserts++; if (out_flags !== 4'b0000) begin $display("FAIL b2b_fsub_flags got %b want 0000", out_flags); errors++; end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    tick;
    asserts++; if (out_valid !== 1'b1 || out_result !== 16'h4700) begin $display("FAIL b2b_fmadd got v=%b %h want v=1 4700", out_valid, out_result); errors++; end
    asserts++; if (fflags !== 4'b0000) begin $display("FAIL b2b_fflags got %b want 0000", fflags); errors++; end
    tick;
  endtask

  task automatic test_overflow_fflags;
    drive(1'b1, 3'd2, 16'h7BFF, 16'h4000, 16'h0000);
    tick;
    drive(1'b1, 3'd0, 16'h3C00, 16'h0000, 16'h3C00);
    tick;
    asserts++; if (out_result !== 16'h7C00) begin $display("FAIL ovf_result got %h want 7c00", out_result); errors++; end
    asserts++; if (out_flags !== 4'b0101) begin $display("FAIL ovf_flags got %b want 0101", out_flags); errors++; end
    asserts++; if (fflags !== 4'b0101) begin $display("FAIL ovf_fflags got %b want 0101", fflags); errors++; end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    tick;
    asserts++; if (out_result !== 16'h4000 || out_flags !== 4'b0000) begin $display("FAIL sticky_fadd got %h/%b want 4000/0000", out_result, out_flags); errors++; end
    asserts++; if (fflags !== 4'b0101) begin $display("FAIL sticky_hold got %b want 0101", fflags); errors++; end
    fflags_clr = 1'b1;
    tick;
    fflags_clr = 1'b0;
    asserts++; if (fflags !== 4'b0000) begin $display("FAIL fflags_clr got %b want 0000", fflags); errors++; end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 16'h4000, 16'h4200, 16'h0000);
    tick;
    drive(1'b1, 3'd0, 16'h3C00, 16'h0000, 16'h3C00);
    tick;
    asserts++; if (out_valid !== 1'b1 || out_result !== 16'h4600) begin $display("FAIL stall_first got v=%b %h want v=1 4600", out_valid, out_result); errors++; end
    asserts++; if (in_ready !== 1'b1) begin $display("FAIL stall_ready1 got %b want 1", in_ready); errors++; end
    drive(1'b1, 3'd3, 16'h4000, 16'h4200, 16'h3C00);
    tick;
    asserts++; if (in_ready !== 1'b0) begin $display("FAIL stall_full got %b want 0", in_ready); errors++; end
    drive(1'b1, 3'd2, 16'h4200, 16'h4200, 16'h0000);
    tick;
    asserts++; if (in_ready !== 1'b0) begin $display("FAIL stall_still_full got %b want 0", in_ready); errors++; end
    asserts++; if (out_result !== 16'h4600) begin $display("FAIL stall_hold got %h want 4600", out_result); errors++; end
    out_ready = 1'b1;
    tick;
    asserts++; if (out_valid !== 1'b1 || out_result !== 16'h4000) begin $display("FAIL stall_b got v=%b %h want v=1 4000", out_valid, out_result); errors++; end
    asserts++; if (in_ready !== 1'b1) begin $display("FAIL stall_reopen got %b want 1", in_ready); errors++; end
    tick;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    asserts++; if (out_valid !== 1'b1 || out_result !== 16'h4700) begin $display("FAIL stall_c got v=%b %h want v=1 4700", out_valid, out_result); errors++; end
    tick;
    asserts++; if (out_valid !== 1'b1 || out_result !== 16'h4880) begin $display("FAIL stall_d got v=%b %h want v=1 4880", out_valid, out_result); errors++; end
    tick;
    asserts++; if (out_valid !== 1'b0) begin $display("FAIL stall_nodup got %b want 0", out_valid); errors++; end
    asserts++; if (out_result !== 16'h4880) begin $display("FAIL stall_data_hold got %h want 4880", out_result); errors++; end
  endtask

  task automatic test_illegal;
    drive(1'b1, 3'd2, 16'h7BFF, 16'h4000, 16'h0000);
    tick;
    drive(1'b1, 3'd7, 16'h1234, 16'h5678, 16'h9ABC);
    tick;
    asserts++; if (fflags !== 4'b0101) begin $display("FAIL ill_pre_fflags got %b want 0101", fflags); errors++; end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    fflags_clr = 1'b1;
    tick;
    fflags_clr = 1'b0;
    asserts++; if (out_valid !== 1'b1 || out_result !== 16'h7E00) begin $display("FAIL ill_result got v=%b %h want v=1 7e00", out_valid, out_result); errors++; end
    asserts++; if (out_flags !== 4'b1000) begin $display("FAIL ill_flags got %b want 1000", out_flags); errors++; end
    asserts++; if (fflags !== 4'b1000) begin $display("FAIL ill_clr_fflags got %b want 1000", fflags); errors++; end
    tick;
    asserts++; if (out_valid !== 1'b0) begin $display("FAIL ill_single got %b want 0", out_valid); errors++; end
  endtask

  task automatic test_reset_midstream;
    fflags_clr = 1'b1;
    tick;
    fflags_clr = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 16'h7BFF, 16'h4000, 16'h0000);
    tick;
    drive(1'b1, 3'd0, 16'h3C00, 16'h0000, 16'h3C00);
    tick;
    drive(1'b1, 3'd3, 16'h4000, 16'h4200, 16'h3C00);
    tick;
    asserts++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || fflags !== 4'b0101) begin $display("FAIL mid_setup got rdy=%b v=%b ff=%b want 0 1 0101", in_ready, out_valid, fflags); errors++; end
    #2 reset = 1'b1;
    #1;
    asserts++; if (in_ready !== 1'b1) begin $display("FAIL mid_in_ready got %b want 1", in_ready); errors++; end
    asserts++; if (out_valid !== 1'b0) begin $display("FAIL mid_out_valid got %b want 0", out_valid); errors++; end
    asserts++; if (out_result !== 16'h0000 || out_flags !== 4'b0000) begin $display("FAIL mid_out_data got %h/%b want 0000/0000", out_result, out_flags); errors++; end
    asserts++; if (fflags !== 4'b0000) begin $display("FAIL mid_fflags got %b want 0000", fflags); errors++; end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    tick;
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 3'd2, 16'h4000, 16'h4200, 16'h0000);
    tick;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    asserts++; if (out_valid !== 1'b0) begin $display("FAIL post_early_valid got %b want 0", out_valid); errors++; end
    tick;
    asserts++; if (out_valid !== 1'b1 || out_result !== 16'h4600) begin $display("FAIL post_result got v=%b %h want v=1 4600", out_valid, out_result); errors++; end
    tick;
    asserts++; if (out_valid !== 1'b0) begin $display("FAIL post_no_stale got %b want 0", out_valid); errors++; end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_back_to_back;
    test_overflow_fflags;
    test_stall;
    test_illegal;
    test_reset_midstream;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end
endmodule
